ram_input_seq: RTL
==================

# ram_input_seq

Upstream control stage for the 4-word × 3-bit lab RAM. It turns two raw push-buttons and the 3-bit switch bank into clean RAM write cycles and a timed read-back scan. It drives the RAM's `address`, `write_enable` and write-data inputs, so the LEDs show each stored word in turn. Button inputs are synchronised and debounced internally; all outputs are registered.

## Interface
- `ADDR_W`, default 2: RAM address width; the RAM depth is 2^ADDR_W.
- `DATA_W`, default 3: RAM word width; equals the switch count.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive differing samples needed to accept a new button level. Minimum 1.
- `SCAN_PERIOD`, default 8: cycles each address is held during a scan. Minimum 1.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `btn_write`  in  1  raw, asynchronous write button.
- `btn_scan`  in  1  raw, asynchronous scan button.
- `sw`  in  DATA_W  switch data. It is sampled directly and must be held stable by the user.
- `address`  out  ADDR_W  RAM address.
- `write_enable`  out  1  RAM write strobe; one cycle per accepted write.
- `din`  out  DATA_W  RAM write data.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `scan_active`  out  1  high while the FSM is in SCAN.

## Operation
- **Per-button front end:**
  - 2-flop synchroniser produces `s2`.
  - Debounce: if `s2` equals the debounced level `deb`, the counter is cleared. Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while `s2` still differs, `deb` takes `s2` and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
  - Pulse = `deb` & ~`deb_d`, where `deb_d` is `deb` delayed one cycle. The pulse lasts one cycle on a rising edge only; releases generate nothing.
- **Registers:** write pointer `wr_ptr` (ADDR_W bits) and scan pointer `scan_ptr`, plus a scan timer of width clog2(SCAN_PERIOD).
- **FSM states:** IDLE, WRITE, SCAN.
- **IDLE:**
  - `address` = `wr_ptr` and `write_enable` = 0.
  - On a write pulse: `din` <= `sw`, then go to WRITE.
  - Otherwise, on a scan pulse: `scan_ptr` <= 0, timer <= 0, then go to SCAN.
  - If both pulses arrive in the same cycle, write wins and the scan pulse is dropped.
- **WRITE:**
  - Lasts exactly one cycle: `write_enable` = 1 and `address` = `wr_ptr`.
  - On exit, `wr_ptr` <= `wr_ptr`+1 modulo 2^ADDR_W (3 wraps to 0), then return to IDLE.
- **SCAN:**
  - `address` = `scan_ptr` and `write_enable` = 0.
  - The timer counts 0..SCAN_PERIOD-1. At SCAN_PERIOD-1 the timer clears and `scan_ptr` increments.
  - After the final address (2^ADDR_W-1) completes its period, go to IDLE. `address` returns to the unchanged `wr_ptr`.
- **Pulses while busy:** any pulse arriving while in WRITE or SCAN is dropped, not queued.
- `din` holds its last written value except during a capture.
- `busy` and `scan_active` are registered from the next state, so they are aligned with `address` and `write_enable`.

## Timing
- **Reset values:** `address`=0, `write_enable`=0, `din`=0, `busy`=0, `scan_active`=0. Internally `wr_ptr`=0, `scan_ptr`=0, timer=0, all `deb`/`deb_d`/counters=0, state=IDLE.
- **Reset mid-operation:** state returns to IDLE immediately, with no completion of a pending write.
- **Write latency:** let `btn_write` rise before edge E1 and stay high.
  - `s2` is high after E2.
  - `deb` is high after E(2+DEBOUNCE_CYCLES).
  - WRITE is entered at E(3+D), so `write_enable` is high from E(3+D) to E(4+D).
  - `address` increments at E(4+D).
  - With D=4, `write_enable` is high only in the cycle after the 7th edge.
- **Scan latency:** a scan pulse enters SCAN on the same schedule. Total duration is 2^ADDR_W × SCAN_PERIOD cycles (32 with defaults). `busy` drops on the first cycle back in IDLE.
- **Re-trigger:** holding a button produces one action; a new action requires a release followed by a press.
- **Address stability:** `address` never changes in the cycle `write_enable` is high.

## Test plan
- **Reset:** assert `rst_n`=0 mid-scan at `address`=2 -> all outputs 0 asynchronously, and IDLE with `address`=0 after release.
- **Single write:** `sw`=3'b101, press `btn_write` for 10 cycles (D=4) -> exactly one `write_enable` cycle after edge 7 with `address`=0 and `din`=3'b101, then `address`=1.
- **Wrap-around:** four presses with `sw`=1,2,3,4 -> writes to addresses 0,1,2,3 with those data, then `address`=0.
- **Debounce:** 3-cycle high glitch on `btn_write` -> no `write_enable`. Bouncing 1-0-1 within 3 cycles followed by stable high -> exactly one write.
- **Scan:** after the wrap-around test, press `btn_scan` -> `address` steps 0,1,2,3, holding each for 8 cycles. `scan_active`=1 for 32 cycles, `write_enable` stays 0, then `address`=0 (`wr_ptr`).
- **Contention:** both buttons pressed on the same cycle -> write only. A `btn_write` press during the scan -> ignored, with no write and `wr_ptr` unchanged.

Source files
------------

// File: rtl/ram_input_seq.sv
// ram_input_seq
// Upstream control stage for a small lab RAM. It turns two raw push-buttons
// and a switch bank into clean single-cycle RAM write cycles and a timed
// read-back scan that walks every address.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_write    raw asynchronous write button
//   btn_scan     raw asynchronous scan button
//   sw           switch data, captured as the write word
//   address      RAM address (write pointer, or scan pointer while scanning)
//   write_enable RAM write strobe, one cycle per accepted write
//   din          RAM write data, holds the last captured switch value
//   busy         high whenever the sequencer is not idle
//   scan_active  high while the read-back scan runs
module ram_input_seq #(
    parameter int ADDR_W          = 2,
    parameter int DATA_W          = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_PERIOD     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_write,
    input  logic              btn_scan,
    input  logic [DATA_W-1:0] sw,
    output logic [ADDR_W-1:0] address,
    output logic              write_enable,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              scan_active
);

    // Counters are at least one bit wide so a period of 1 stays legal.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(SCAN_PERIOD - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;

    // Bit 0 = write button, bit 1 = scan button.
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;

    assign btn_raw = {btn_scan, btn_write};

    // ------------------------------------------------------------------
    // Per-button front end: 2-flop synchroniser, counting debouncer and
    // rising-edge detector producing a single-cycle press pulse.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_d_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    // Any sample agreeing with the accepted level restarts
                    // the count, so only an unbroken run of differing
                    // samples can flip the debounced level.
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            // Press edge only; releases produce nothing.
            assign btn_pulse[gi] = deb_reg & ~deb_d_reg;
        end
    endgenerate

    logic write_pulse;
    logic scan_pulse;

    assign write_pulse = btn_pulse[0];
    assign scan_pulse  = btn_pulse[1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [1:0]        state_reg,    state_next;
    logic [ADDR_W-1:0] wr_ptr_reg,   wr_ptr_next;
    logic [ADDR_W-1:0] scan_ptr_reg, scan_ptr_next;
    logic [TMR_W-1:0]  timer_reg,    timer_next;
    logic [DATA_W-1:0] din_reg,      din_next;
    logic [ADDR_W-1:0] address_reg,  address_next;
    logic              we_reg,       we_next;
    logic              busy_reg,     busy_next;
    logic              scan_act_reg, scan_act_next;

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        scan_ptr_next = scan_ptr_reg;
        timer_next    = timer_reg;
        din_next      = din_reg;

        case (state_reg)
            ST_IDLE: begin
                // Write has priority; a simultaneous scan press is lost.
                if (write_pulse) begin
                    din_next   = sw;
                    state_next = ST_WRITE;
                end else if (scan_pulse) begin
                    scan_ptr_next = '0;
                    timer_next    = '0;
                    state_next    = ST_SCAN;
                end
            end
            ST_WRITE: begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
                state_next  = ST_IDLE;
            end
            ST_SCAN: begin
                if (timer_reg == TMR_LAST) begin
                    timer_next    = '0;
                    scan_ptr_next = scan_ptr_reg + 1'b1;
                    if (scan_ptr_reg == PTR_LAST) begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so that address,
        // strobe and status flags all change on the same edge.
        address_next  = (state_next == ST_SCAN) ? scan_ptr_next : wr_ptr_next;
        we_next       = (state_next == ST_WRITE);
        busy_next     = (state_next != ST_IDLE);
        scan_act_next = (state_next == ST_SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            scan_ptr_reg <= '0;
            timer_reg    <= '0;
            din_reg      <= '0;
            address_reg  <= '0;
            we_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            scan_act_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            scan_ptr_reg <= scan_ptr_next;
            timer_reg    <= timer_next;
            din_reg      <= din_next;
            address_reg  <= address_next;
            we_reg       <= we_next;
            busy_reg     <= busy_next;
            scan_act_reg <= scan_act_next;
        end
    end

    assign address      = address_reg;
    assign write_enable = we_reg;
    assign din          = din_reg;
    assign busy         = busy_reg;
    assign scan_active  = scan_act_reg;

endmodule
